// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared state encoding and averaging depth for period_meter.
// Contents: state_t (ST_IDLE, ST_MEASURE) and AVG_SHIFT (log2 of the averaging depth).
package period_meter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_MEASURE = 1'b1} state_t;
  localparam int AVG_SHIFT = 2;
endpackage

// File: rtl/sync_rise_detect.sv
// sync_rise_detect: two-flop synchronizer plus history flop producing a one-cycle rising-edge strobe.
// Ports: clk, rst_btn (sync, active low), d (async input), rise (edge strobe, from synchronized flops only).
module sync_rise_detect (
  input  logic clk,
  input  logic rst_btn,
  input  logic d,
  output logic rise
);
  logic s1, s2, s3;
  always_ff @(posedge clk)
    if (!rst_btn) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {d, s1, s2};
  assign rise = s2 & ~s3;
endmodule

// File: rtl/period_meter.sv
// period_meter: measures the period of a slow asynchronous square wave in clk cycles.
// Ports: clk, rst_btn (sync, active low), sig_in (async), period (last result),
//        valid (one-cycle update strobe), timeout (level, cleared by next valid), armed (in MEASURE).
// Option: define PERIOD_METER_AVG_EN to report the truncated mean of every four measurements.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int          COUNT_WIDTH = 32,
  parameter int unsigned TIMEOUT     = 12000000 - 1
) (
  input  logic                   clk,
  input  logic                   rst_btn,
  input  logic                   sig_in,
  output logic [COUNT_WIDTH-1:0] period,
  output logic                   valid,
  output logic                   timeout,
  output logic                   armed
);
  localparam logic [COUNT_WIDTH-1:0] LIMIT = COUNT_WIDTH'(TIMEOUT);
  state_t state;
  logic rise;
  logic [COUNT_WIDTH-1:0] cnt;
  sync_rise_detect u_sync (.clk(clk), .rst_btn(rst_btn), .d(sig_in), .rise(rise));
`ifdef PERIOD_METER_AVG_EN
  logic [1:0] idx;
  logic [COUNT_WIDTH+1:0] acc, sum;
  assign sum = acc + (COUNT_WIDTH+2)'(cnt);
`endif
  // The counter saturates at LIMIT; an edge in that same cycle still reports LIMIT.
  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      period  <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      armed   <= 1'b0;
`ifdef PERIOD_METER_AVG_EN
      idx     <= 2'd0;
      acc     <= '0;
`endif
    end else begin
      valid <= 1'b0;
      if (state == ST_IDLE) begin
        if (rise) begin
          state <= ST_MEASURE;
          armed <= 1'b1;
          cnt   <= COUNT_WIDTH'(1);
        end
      end else if (rise) begin
        cnt <= COUNT_WIDTH'(1);
`ifdef PERIOD_METER_AVG_EN
        idx <= idx + 2'd1;
        acc <= (&idx) ? '0 : sum;
        if (&idx) begin
          period  <= COUNT_WIDTH'(sum >> AVG_SHIFT);
          valid   <= 1'b1;
          timeout <= 1'b0;
        end
`else
        period  <= cnt;
        valid   <= 1'b1;
        timeout <= 1'b0;
`endif
      end else if (cnt == LIMIT) begin
        state   <= ST_IDLE;
        armed   <= 1'b0;
        timeout <= 1'b1;
`ifdef PERIOD_METER_AVG_EN
        idx     <= 2'd0;
        acc     <= '0;
`endif
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed self-checking bench for period_meter (COUNT_WIDTH=16, TIMEOUT=1000).
module tb_period_meter;
  logic clk = 1'b0;
  logic rst_btn = 1'b0;
  logic sig_in = 1'b0;
  logic [15:0] period;
  logic valid, timeout, armed;
  int vectors = 0, miscompares = 0;
  int cyc = 0, vcnt = 0, vper = 0, vcyc = 0, vfirst = 0, to_cyc = 0, t_edge = 0;
  logic to_prev = 1'b0;

  period_meter #(.COUNT_WIDTH(16), .TIMEOUT(1000)) dut (
    .clk(clk), .rst_btn(rst_btn), .sig_in(sig_in),
    .period(period), .valid(valid), .timeout(timeout), .armed(armed)
  );

  always #5 clk = ~clk;

  // Observe outputs 2 ns after each rising edge; cyc counts rising edges seen.
  always @(posedge clk) begin
    #2;
    cyc = cyc + 1;
    if (valid === 1'b1) begin
      vcnt = vcnt + 1;
      vper = int'(period);
      vcyc = cyc;
      if (vcnt == 1) vfirst = int'(period);
    end
    if (timeout === 1'b1 && to_prev !== 1'b1) to_cyc = cyc;
    to_prev = timeout;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    vcnt = 0;
    vfirst = 0;
  endtask

  // n rising edges spaced p cycles apart, driven just after a falling edge.
  task automatic pulses(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      t_edge = cyc;
      repeat (p / 2) @(negedge clk);
      sig_in = 1'b0;
      repeat (p - p / 2) @(negedge clk);
    end
  endtask

  task automatic wait_to();
    for (int i = 0; i < 2000 && timeout !== 1'b1; i++) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_period", 32'(period), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_armed", 32'(armed), 0);
    rst_btn = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_armed", 32'(armed), 0);
`ifdef PERIOD_METER_AVG_EN
    clr();
    pulses(10, 1); pulses(11, 1); pulses(12, 1); pulses(14, 1); pulses(10, 1);
    chk("avg_count", vcnt, 1);
    chk("avg_value", vper, 11);
    chk("avg_period_out", 32'(period), 11);
`else
    clr();
    pulses(8, 6);
    chk("p8_count", vcnt, 5);
    chk("p8_first", vfirst, 8);
    chk("p8_last", vper, 8);
    chk("p8_latency", vcyc - t_edge, 3);
    chk("p8_timeout", 32'(timeout), 0);
    chk("p8_armed", 32'(armed), 1);
    pulses(20, 1);
    clr();
    pulses(20, 3);
    chk("p20_count", vcnt, 3);
    chk("p20_value", vper, 20);
    clr();
    pulses(50, 3);
    chk("sw_count", vcnt, 3);
    chk("sw_first", vfirst, 20);
    chk("sw_last", vper, 50);
    to_cyc = 0;
    sig_in = 1'b1;
    t_edge = cyc;
    repeat (10) @(negedge clk);
    sig_in = 1'b0;
    wait_to();
    chk("to_delay", to_cyc - t_edge, 1003);
    chk("to_level", 32'(timeout), 1);
    chk("to_period_kept", 32'(period), 50);
    chk("to_armed", 32'(armed), 0);
    clr();
    pulses(30, 2);
    chk("rearm_count", vcnt, 1);
    chk("rearm_period", 32'(period), 30);
    chk("rearm_timeout", 32'(timeout), 0);
    chk("rearm_latency", vcyc - t_edge, 3);
    pulses(1000, 1);
    clr();
    sig_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("lim_count", vcnt, 1);
    chk("lim_period", vper, 1000);
    chk("lim_timeout", 32'(timeout), 0);
    sig_in = 1'b0;
    repeat (996) @(negedge clk);
    clr();
    sig_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("over_timeout", 32'(timeout), 1);
    chk("over_count", vcnt, 0);
    chk("over_armed", 32'(armed), 1);
    sig_in = 1'b0;
    repeat (5) @(negedge clk);
    pulses(40, 3);
    chk("p40_last", vper, 40);
    repeat (10) @(negedge clk);
    rst_btn = 1'b0;
    @(negedge clk);
    chk("mid_rst_period", 32'(period), 0);
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_timeout", 32'(timeout), 0);
    chk("mid_rst_armed", 32'(armed), 0);
    rst_btn = 1'b1;
    clr();
    pulses(40, 3);
    chk("post_rst_count", vcnt, 2);
    chk("post_rst_first", vfirst, 40);
    chk("post_rst_period", 32'(period), 40);
    sig_in = 1'b1;
    rst_btn = 1'b0;
    repeat (2) @(negedge clk);
    rst_btn = 1'b1;
    clr();
    repeat (6) @(negedge clk);
    chk("high_rel_armed", 32'(armed), 1);
    chk("high_rel_count", vcnt, 0);
    sig_in = 1'b0;
    repeat (5) @(negedge clk);
    pulses(10, 1);
    clr();
    pulses(11, 1); pulses(12, 1); pulses(14, 1); pulses(10, 1);
    chk("seq_count", vcnt, 4);
    chk("seq_first", vfirst, 10);
    chk("seq_last", vper, 14);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/period_meter.md
# period_meter

Input-side measurement block that is the receiving end of the team's clock dividers: it accepts a slow square wave, such as a divided clock or an external pulse train, and reports its period in `clk` cycles. It synchronizes the asynchronous input, detects rising edges, counts cycles between consecutive edges, and publishes each result with a one-cycle valid strobe. If no edge arrives within a programmable limit, it flags a timeout. It sits between board inputs or divider outputs and LED or status logic in top-level designs.

## Interface
- `COUNT_WIDTH`, default 32: width of the cycle counter and `period` output.
- `TIMEOUT`, default 12000000 - 1: largest measurable period in cycles (1 s at 12 MHz); must be < 2^COUNT_WIDTH and ≥ 2.
- `clk` input 1: system clock (12 MHz on the board).
- `rst_btn` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `sig_in` input 1: asynchronous signal under measurement.
- `period` output COUNT_WIDTH: last measured period in `clk` cycles.
- `valid` output 1: one-cycle pulse when `period` updates.
- `timeout` output 1: level, set when the measurement limit expires.
- `armed` output 1: high while in MEASURE state.

## Operation
- Input path:
  - Two-flop synchronizer (`s1`, `s2`), then a history flop `s3`.
  - Rising edge `rise = s2 & ~s3`.
  - All three flops reset to 0.
- State machine with two states: IDLE and MEASURE.
- IDLE:
  - On `rise`, load `cnt <= 1` and go to MEASURE.
  - `period` is unchanged. `valid` stays 0.
- MEASURE, when `rise` occurs:
  - `period <= cnt`, `valid <= 1`, `timeout <= 0`, `cnt <= 1`.
  - Stay in MEASURE.
- MEASURE, no `rise`, and `cnt == TIMEOUT`:
  - Go to IDLE, `timeout <= 1`.
  - `period` is unchanged. `cnt` is held.
- MEASURE, otherwise: `cnt <= cnt + 1`.
- Period definition: a steady input with rising edges every P cycles reports exactly P.
- The counter never wraps; it stops at TIMEOUT.
- `rise` and `cnt == TIMEOUT` in the same cycle: the edge wins, and `period = TIMEOUT` is reported with `valid`.
- Minimum reportable period is 2, because an edge needs one low sample and one high sample.
- `timeout` stays high until the next `valid`. The first edge after a timeout only re-arms the block; a measurement follows on the second edge.
- Reset, including mid-measurement, clears all outputs on the next clock edge:
  - `period = 0`, `valid = 0`, `timeout = 0`, `armed = 0`.
  - `cnt = 0`, state = IDLE, sync flops = 0.
- If `sig_in` is already high at reset release, the resulting `rise` only arms the block.

## Timing
- `sig_in` is first sampled high by `s1` at clock edge k. Then:
  - `rise` is high during the cycle after edge k+1.
  - `valid` and `period` are registered at edge k+2.
  - Latency is 3 edges from sampling to the outputs.
- `valid` is high for exactly one cycle per measurement.
- `armed` rises at the same edge that loads `cnt <= 1` from IDLE.
- `timeout` rises at the edge where MEASURE exits to IDLE, which is TIMEOUT cycles after the last edge was registered.
- All outputs are registered. There is no combinational path from `sig_in`.

## Configuration
- Macro `PERIOD_METER_AVG_EN`.
- When defined:
  - A 2-bit measurement index and a COUNT_WIDTH+2 accumulator sum four consecutive measurements.
  - Every 4th measurement, `period <= sum >> 2` (truncated) and `valid` pulses.
  - Intermediate measurements do not pulse `valid`.
  - A timeout or reset clears the accumulator and the index.
- When undefined: every measurement updates `period` and pulses `valid`, as above.

## Structure
- Package `period_meter_pkg`:
  - State encoding constants `ST_IDLE = 1'b0` and `ST_MEASURE = 1'b1`.
  - Averaging depth constant `AVG_SHIFT = 2`.
- Sub-module `sync_rise_detect`:
  - Ports: `clk`, `rst_btn`, `d`, `rise`.
  - Holds `s1`/`s2`/`s3`. It is reusable for button inputs.
- The top-level `period_meter` holds the FSM, counter, and output registers.

## Test plan
Bench uses TIMEOUT=1000, COUNT_WIDTH=16.
- Square wave with period 8 cycles, 6 edges: the first edge only sets `armed`; then 5 `valid` pulses, each with `period = 8`, and `timeout = 0`.
- Square wave with period 20, then switch to period 50: the reported periods go 20 → 50. The first post-switch value equals the actual edge spacing.
- One edge, then the input holds low: `timeout` rises 1000 cycles after the edge; `period` keeps its prior value; `armed = 0`. Next two edges 30 apart → `valid`, `period = 30`, `timeout = 0`.
- Edge spacing exactly 1000 → `valid` with `period = 1000` and no timeout. Spacing 1001 → timeout, no `valid`.
- Assert `rst_btn = 0` mid-count while measuring period 40: the next edge clears all outputs to 0. After release, the first edge arms and the second reports `period = 40`.
- With `PERIOD_METER_AVG_EN`, edge spacings 10, 11, 12, 14 → a single `valid` with `period = 11`.
